// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller:
// FSM state encoding, opcode/func constants and the instruction classifier.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    IC_ADDU    = 3'd0,
    IC_ADDIU   = 3'd1,
    IC_LW      = 3'd2,
    IC_SW      = 3'd3,
    IC_JR      = 3'd4,
    IC_ILLEGAL = 3'd5
  } iclass_t;

  typedef struct packed {
    logic ir_we;
    logic ab_we;
    logic aluout_we;
    logic pc_we;
    logic alu_src;
    logic pc_sel;
    logic wr_sel;
    logic mem_to_reg;
    logic reg_wr_en;
    logic dmem_en;
    logic dmem_rd_wr;
  } ctrl_t;

  // Quiescent control word: nothing written, data memory direction parked at read.
  localparam ctrl_t CTRL_IDLE = '{dmem_rd_wr: 1'b1, default: 1'b0};

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
    iclass_t c;
    c = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU) begin
          c = IC_ADDU;
        end else if (fn == FN_JR) begin
          c = IC_JR;
        end
      end
      OP_ADDIU: c = IC_ADDIU;
      OP_LW:    c = IC_LW;
      OP_SW:    c = IC_SW;
      default:  c = IC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive memory-busy cycles and flags the cycle in which the
// run reaches MAX_STALL, so the controller can give up and halt.
module stall_watchdog #(
  parameter int MAX_STALL = 16
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_busy,
  output logic o_expire
);

  localparam int CW = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;

  logic [CW-1:0] r_count;

  assign o_expire = i_busy && (r_count == CW'(MAX_STALL - 1));

  // i_busy is only high while the FSM is parked in a wait state, so any
  // non-busy cycle is also the cycle the state moves on: clearing here
  // covers both "run broken" and "state changed".
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_busy && !o_expire) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// wait states, a stall watchdog that halts the core, and retire counting.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        ir_we,
  output logic        ab_we,
  output logic        aluout_we,
  output logic        pc_we,
  output logic        alu_src,
  output logic        pc_sel,
  output logic        wr_sel,
  output logic        mem_to_reg,
  output logic        reg_wr_en,
  output logic        dmem_en,
  output logic        dmem_rd_wr,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal,
  output logic        error
);

  state_t      r_state;
  logic [31:0] r_retired;
  logic        r_illegal;
  logic        r_error;

  iclass_t w_class;
  logic    w_mem_op;
  logic    w_imm_form;
  logic    w_wr_reg;
  logic    w_busy;
  logic    w_expire;
  ctrl_t   w_ctrl;

  assign w_class    = classify(opcode, func);
  assign w_mem_op   = (w_class == IC_LW) || (w_class == IC_SW);
  assign w_imm_form = (w_class == IC_ADDIU) || w_mem_op;
  assign w_wr_reg   = (w_class == IC_ADDU) || (w_class == IC_ADDIU) || (w_class == IC_LW);
  assign w_busy     = ((r_state == ST_FETCH) && imem_busy) ||
                      ((r_state == ST_MEM) && dmem_busy);

  stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_watchdog (
    .clk       (clk),
    .i_reset_n (reset),
    .i_busy    (w_busy),
    .o_expire  (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_FETCH;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_expire) begin
            r_state <= ST_HALT;
            r_error <= 1'b1;
          end else if (!imem_busy) begin
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_class == IC_ILLEGAL) begin
            r_illegal <= 1'b1;
          end
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_state <= w_mem_op ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (w_expire) begin
            r_state <= ST_HALT;
            r_error <= 1'b1;
          end else if (!dmem_busy) begin
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_retired <= r_retired + 32'd1;
          r_state   <= ST_FETCH;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  // Gating on reset kills every strobe in the very cycle reset is low,
  // before the synchronous reset has moved the state register.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    if (reset) begin
      case (r_state)
        ST_FETCH: begin
          w_ctrl.ir_we = !imem_busy;
        end
        ST_DECODE: begin
          w_ctrl.ab_we   = 1'b1;
          w_ctrl.alu_src = w_imm_form;
          w_ctrl.wr_sel  = w_imm_form;
        end
        ST_EXEC: begin
          w_ctrl.aluout_we = 1'b1;
          w_ctrl.alu_src   = w_imm_form;
          w_ctrl.wr_sel    = w_imm_form;
        end
        ST_MEM: begin
          w_ctrl.dmem_en    = 1'b1;
          w_ctrl.dmem_rd_wr = (w_class != IC_SW);
          w_ctrl.mem_to_reg = (w_class == IC_LW);
          w_ctrl.alu_src    = w_imm_form;
          w_ctrl.wr_sel     = w_imm_form;
        end
        ST_WB: begin
          w_ctrl.pc_we      = 1'b1;
          w_ctrl.pc_sel     = (w_class == IC_JR);
          w_ctrl.reg_wr_en  = w_wr_reg;
          w_ctrl.mem_to_reg = (w_class == IC_LW);
          w_ctrl.alu_src    = w_imm_form;
          w_ctrl.wr_sel     = w_imm_form;
        end
        default: begin
          w_ctrl = CTRL_IDLE;
        end
      endcase
    end
  end

  assign ir_we      = w_ctrl.ir_we;
  assign ab_we      = w_ctrl.ab_we;
  assign aluout_we  = w_ctrl.aluout_we;
  assign pc_we      = w_ctrl.pc_we;
  assign alu_src    = w_ctrl.alu_src;
  assign pc_sel     = w_ctrl.pc_sel;
  assign wr_sel     = w_ctrl.wr_sel;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign reg_wr_en  = w_ctrl.reg_wr_en;
  assign dmem_en    = w_ctrl.dmem_en;
  assign dmem_rd_wr = w_ctrl.dmem_rd_wr;

  assign state   = r_state;
  assign retired = r_retired;
  assign illegal = r_illegal;
  assign error   = r_error;

endmodule
